// File: rtl/adc_capture_ctrl.sv
// ADC capture sequencer: divides hclk into adc_clk, waits for a level-crossing trigger and
// streams a block of samples into the capture RAM write port.
module adc_capture_ctrl #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [15:0]       cfg_div,
  input  logic [ADDR_W:0]   cfg_len,
  input  logic [1:0]        cfg_trig_mode,
  input  logic [DATA_W-1:0] cfg_trig_level,
  input  logic [DATA_W-1:0] adc_data,
  output logic              adc_clk,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   sample_cnt
);

  localparam logic [ADDR_W:0] Depth = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {StIdle, StArmed, StWaitTrig, StCapture, StDone} state_e;

  state_e              state_q, state_d;
  logic [15:0]         div_q, div_cnt_q, div_cnt_d;
  logic [ADDR_W:0]     len_q, sample_cnt_q, sample_cnt_d;
  logic [1:0]          mode_q;
  logic [DATA_W-1:0]   level_q, s_cur_q, mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                adc_clk_q, adc_clk_d, mem_we_q, done_q, done_d;

  logic [15:0]         div_max, half;
  logic [ADDR_W:0]     len_in_eff, cnt_inc;
  logic                running, running_d, tick, rise_hit, fall_hit, last, write, latch;

  assign div_max    = (div_q == 16'd0) ? 16'd1 : div_q;
  assign half       = div_max >> 1;
  assign running    = (state_q == StArmed) || (state_q == StWaitTrig) || (state_q == StCapture);
  assign running_d  = (state_d == StArmed) || (state_d == StWaitTrig) || (state_d == StCapture);
  assign tick       = running && (div_cnt_q == div_max);
  // s_cur_q still holds the previous sample while adc_data is the one being taken
  assign rise_hit   = (s_cur_q < level_q) && (adc_data >= level_q);
  assign fall_hit   = (s_cur_q > level_q) && (adc_data <= level_q);
  assign len_in_eff = ((cfg_len == '0) || (cfg_len > Depth)) ? Depth : cfg_len;
  assign cnt_inc    = sample_cnt_q + 1'b1;
  assign last       = (cnt_inc == len_q);

  always_comb begin
    state_d = state_q;
    write   = 1'b0;
    latch   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cfg_start) begin
          state_d = StArmed;
          latch   = 1'b1;
        end
      end
      StArmed: begin
        if (tick) begin
          if ((mode_q == 2'd0) || (mode_q == 2'd3)) begin
            write   = 1'b1;
            state_d = last ? StDone : StCapture;
          end else begin
            state_d = StWaitTrig;
          end
        end
      end
      StWaitTrig: begin
        if (tick && (((mode_q == 2'd1) && rise_hit) || ((mode_q == 2'd2) && fall_hit))) begin
          write   = 1'b1;
          state_d = last ? StDone : StCapture;
        end
      end
      StCapture: begin
        if (tick) begin
          write   = 1'b1;
          state_d = last ? StDone : StCapture;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Abort overrides start and a coinciding final write
    if (cfg_abort) begin
      state_d = StIdle;
      write   = 1'b0;
      latch   = 1'b0;
    end
  end

  always_comb begin
    div_cnt_d    = div_cnt_q + 16'd1;
    if (!running || (state_d == StIdle) || (div_cnt_q == div_max)) div_cnt_d = 16'd0;
    adc_clk_d    = running_d && (div_cnt_d > half);
    sample_cnt_d = sample_cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    done_d       = done_q;
    if (latch) begin
      sample_cnt_d = '0;
      done_d       = 1'b0;
    end
    if (write) begin
      mem_addr_d   = sample_cnt_q[ADDR_W-1:0];
      mem_wdata_d  = adc_data;
      sample_cnt_d = cnt_inc;
      if (last) done_d = 1'b1;
    end
    if (cfg_abort) done_d = 1'b0;
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q      <= StIdle;
      div_q        <= '0;
      len_q        <= '0;
      mode_q       <= '0;
      level_q      <= '0;
      div_cnt_q    <= '0;
      adc_clk_q    <= 1'b0;
      s_cur_q      <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      done_q       <= 1'b0;
      sample_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      adc_clk_q    <= adc_clk_d;
      mem_we_q     <= write;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      done_q       <= done_d;
      sample_cnt_q <= sample_cnt_d;
      if (tick) s_cur_q <= adc_data;
      if (latch) begin
        div_q   <= cfg_div;
        len_q   <= len_in_eff;
        mode_q  <= cfg_trig_mode;
        level_q <= cfg_trig_level;
      end
    end
  end

  assign adc_clk    = adc_clk_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = running;
  assign done       = done_q;
  assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Bench for adc_capture_ctrl: directed table, randomized captures against a sample-level
// model, plus abort/reset corner sequences.
module tb_adc_capture_ctrl;
  localparam int SAMP = 1100;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        cfg_start = 1'b0;
  logic        cfg_abort = 1'b0;
  logic [15:0] cfg_div = '0;
  logic [10:0] cfg_len = '0;
  logic [1:0]  cfg_trig_mode = '0;
  logic [7:0]  cfg_trig_level = '0;
  logic [7:0]  adc_data;
  logic        adc_clk, mem_we, busy, done;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [10:0] sample_cnt;

  adc_capture_ctrl #(.ADDR_W(10), .DATA_W(8)) dut (
    .hclk(hclk), .hresetn(hresetn), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_div(cfg_div), .cfg_len(cfg_len), .cfg_trig_mode(cfg_trig_mode),
    .cfg_trig_level(cfg_trig_level), .adc_data(adc_data), .adc_clk(adc_clk),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
    .done(done), .sample_cnt(sample_cnt)
  );

  always #5 hclk = ~hclk;

  int cyc = 0;
  always @(posedge hclk) cyc <= cyc + 1;

  // ADC model: presents samples[idx], advancing to the next sample after each adc_clk fall
  logic [7:0] samples [SAMP];
  int         idx = 0;
  logic       feed_rst = 1'b0;
  always @(negedge adc_clk or posedge feed_rst) begin
    if (feed_rst) idx <= 0;
    else if (idx < SAMP - 1) idx <= idx + 1;
  end
  assign adc_data = samples[idx];

  typedef struct packed {
    logic [9:0]  addr;
    logic [7:0]  data;
    logic [31:0] cyc;
  } wr_t;
  wr_t wr_q[$];
  always @(negedge hclk) if (mem_we) wr_q.push_back({mem_addr, mem_wdata, 32'(cyc)});

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge hclk);
    #1;
  endtask

  // Sample-level reference: locate the trigger sample, then expect len consecutive samples,
  // sample k landing in RAM (k+1) sample periods after the start pulse.
  task automatic run_case(input int div, input int len, input int mode, input int level,
                          input bit poke, output int got_n, output int got_first);
    int p, len_eff, k0, base, start_cyc, budget, n;
    bit poked;
    wr_t w;
    p = ((div == 0) ? 1 : div) + 1;
    len_eff = (len == 0 || len > 1024) ? 1024 : len;
    k0 = -1;
    if (mode == 0 || mode == 3) k0 = 0;
    else begin
      for (int k = 1; k < SAMP; k++) begin
        if (mode == 1 && samples[k-1] < level && samples[k] >= level) begin k0 = k; break; end
        if (mode == 2 && samples[k-1] > level && samples[k] <= level) begin k0 = k; break; end
      end
    end
    feed_rst = 1'b1;
    step();
    feed_rst = 1'b0;
    base = wr_q.size();
    cfg_div = 16'(div);
    cfg_len = 11'(len);
    cfg_trig_mode = 2'(mode);
    cfg_trig_level = 8'(level);
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    start_cyc = cyc;
    chk("busy_after_start", busy, 1);
    chk("done_cleared", done, 0);
    chk("cnt_cleared", sample_cnt, 0);
    budget = (k0 >= 0) ? p * (k0 + len_eff + 3) : p * 20;
    n = 0;
    poked = 1'b0;
    while (busy && n < budget) begin
      if (poke && !poked && (wr_q.size() - base) == 1) begin
        cfg_start = 1'b1;
        cfg_div = 16'd9;
        cfg_len = 11'd2;
        cfg_trig_mode = 2'd1;
        poked = 1'b1;
      end
      step();
      cfg_start = 1'b0;
      n++;
    end
    got_n = wr_q.size() - base;
    got_first = (got_n > 0) ? int'(wr_q[base].data) : -1;
    if (k0 >= 0) begin
      chk("end_busy", busy, 0);
      chk("end_done", done, 1);
      chk("end_sample_cnt", sample_cnt, len_eff);
      chk("write_count", got_n, len_eff);
      for (int j = 0; j < got_n && j < len_eff && k0 + j < SAMP; j++) begin
        w = wr_q[base + j];
        chk("wr_addr", w.addr, j);
        chk("wr_data", w.data, samples[k0 + j]);
        chk("wr_time", w.cyc - start_cyc, (k0 + j + 1) * p);
      end
    end else begin
      chk("untriggered_busy", busy, 1);
      chk("untriggered_writes", got_n, 0);
      cfg_abort = 1'b1;
      step();
      cfg_abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      step();
      step();
      chk("abort_writes", wr_q.size() - base, 0);
    end
  endtask

  typedef struct {
    int            div;
    int            len;
    int            mode;
    int            level;
    logic [0:5][7:0] s;
    int            exp_first;
    int            exp_n;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int got_n, got_first, base, start_cyc, n;
    vecs[0] = '{3, 4,    0, 8'h00, {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}, 8'h01, 4};
    vecs[1] = '{1, 3,    1, 8'h80, {8'h10, 8'h70, 8'h90, 8'hA0, 8'hB0, 8'hC0}, 8'h90, 3};
    vecs[2] = '{0, 2,    2, 8'h40, {8'h90, 8'h50, 8'h40, 8'h30, 8'h20, 8'h10}, 8'h40, 2};
    vecs[3] = '{2, 1,    3, 8'h00, {8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA}, 8'h55, 1};
    vecs[4] = '{1, 2,    1, 8'h80, {8'h90, 8'hA0, 8'h10, 8'h85, 8'h20, 8'h20}, 8'h85, 2};
    vecs[5] = '{2, 3,    2, 8'h80, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, -1,    0};
    vecs[6] = '{1, 2,    1, 8'h80, {8'h7F, 8'h80, 8'h81, 8'h82, 8'h83, 8'h84}, 8'h80, 2};
    vecs[7] = '{0, 0,    0, 8'h00, {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}, 8'h01, 1024};
    vecs[8] = '{1, 1500, 0, 8'h00, {8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6}, 8'hA1, 1024};
    for (int i = 0; i < SAMP; i++) samples[i] = 8'(i);

    step();
    step();
    step();
    chk("rst_adc_clk", adc_clk, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sample_cnt", sample_cnt, 0);
    hresetn = 1'b1;
    step();

    for (int v = 0; v < 9; v++) begin
      for (int i = 0; i < SAMP; i++) samples[i] = vecs[v].s[(i < 5) ? i : 5];
      base = wr_q.size();
      run_case(vecs[v].div, vecs[v].len, vecs[v].mode, vecs[v].level, 1'b0, got_n, got_first);
      chk("vec_write_count", got_n, vecs[v].exp_n);
      if (vecs[v].exp_n > 0) begin
        chk("vec_first_data", got_first, vecs[v].exp_first);
        chk("vec_last_addr", wr_q[base + got_n - 1].addr, vecs[v].exp_n - 1);
      end
      step();
    end

    // adc_clk shape for div=3: low for counts 0..1, high for counts 2..3
    for (int i = 0; i < SAMP; i++) samples[i] = 8'(i + 1);
    feed_rst = 1'b1;
    step();
    feed_rst = 1'b0;
    cfg_div = 16'd3;
    cfg_len = 11'd4;
    cfg_trig_mode = 2'd0;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("adc_clk_shape", adc_clk, ((i % 4) >= 2) ? 1 : 0);
      step();
    end
    chk("shape_done", done, 1);
    chk("shape_adc_clk_low", adc_clk, 0);
    step();

    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < SAMP; i++) samples[i] = (i <= 200) ? 8'($urandom_range(0, 255)) : samples[200];
      run_case(int'($urandom_range(0, 4)), int'($urandom_range(1, 12)), int'($urandom_range(0, 3)),
               int'($urandom_range(32, 224)), 1'($urandom_range(0, 1)), got_n, got_first);
      step();
    end

    // Abort coinciding with the final write tick
    for (int i = 0; i < SAMP; i++) samples[i] = 8'(i + 16);
    feed_rst = 1'b1;
    step();
    feed_rst = 1'b0;
    base = wr_q.size();
    cfg_div = 16'd3;
    cfg_len = 11'd2;
    cfg_trig_mode = 2'd0;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    start_cyc = cyc;
    n = 0;
    while (cyc < start_cyc + 7 && n < 50) begin
      step();
      n++;
    end
    cfg_abort = 1'b1;
    step();
    cfg_abort = 1'b0;
    chk("collide_mem_we", mem_we, 0);
    chk("collide_done", done, 0);
    chk("collide_busy", busy, 0);
    step();
    step();
    chk("collide_writes", wr_q.size() - base, 1);
    chk("collide_done_later", done, 0);

    // Asynchronous reset in the middle of a capture
    feed_rst = 1'b1;
    step();
    feed_rst = 1'b0;
    base = wr_q.size();
    cfg_div = 16'd1;
    cfg_len = 11'd8;
    cfg_trig_mode = 2'd0;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    n = 0;
    while ((wr_q.size() - base) < 3 && n < 40) begin
      step();
      n++;
    end
    chk("pre_reset_busy", busy, 1);
    hresetn = 1'b0;
    #1;
    chk("midrst_adc_clk", adc_clk, 0);
    chk("midrst_mem_we", mem_we, 0);
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_mem_wdata", mem_wdata, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_sample_cnt", sample_cnt, 0);
    step();
    step();
    hresetn = 1'b1;
    base = wr_q.size();
    for (int i = 0; i < 20; i++) step();
    chk("postrst_writes", wr_q.size() - base, 0);
    chk("postrst_busy", busy, 0);
    chk("postrst_cnt", sample_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
